// File: rtl/miriscv_btb_upd_ctrl.sv
// ---------------------------------------------------------------------------
// miriscv_btb_upd_ctrl
//
// Update sequencer for the branch target buffer. Update and invalidate
// requests from the execute-stage feedback path are queued in a small
// circular FIFO. In RUN they are drained into the BTB write port at one per
// cycle. While the BTB is self-initialising, requests are held off. On
// request, a full-table invalidate walk runs across every BTB index.
//
// Parameters
//   BTB_SIZE    number of BTB entries (power of two)
//   FIFO_DEPTH  update FIFO entries (power of two, >= 2)
//
// Ports
//   clk_i, arstn_i        clock and asynchronous active-low reset
//   upd_valid_i/ready_o   feedback update handshake
//   upd_pc_i, upd_target_i, upd_branch_i, upd_jal_i, upd_jalr_i, upd_inv_i
//                         update payload
//   flush_all_req_i       single-cycle pulse requesting a full invalidate
//   flush_all_done_o      one-cycle pulse when the full invalidate completes
//   busy_o                high while initialising or walking
//   fifo_cnt_o            current FIFO occupancy
//   btb_init_i            BTB self-initialisation in progress
//   btb_upd_o, btb_pc_o, btb_target_o, btb_branch_o, btb_jal_o, btb_jalr_o,
//   btb_flush_o           BTB write port
// ---------------------------------------------------------------------------
module miriscv_btb_upd_ctrl #(
    parameter int BTB_SIZE   = 1024,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          arstn_i,

    input  logic                          upd_valid_i,
    output logic                          upd_ready_o,
    input  logic [31:0]                   upd_pc_i,
    input  logic [31:0]                   upd_target_i,
    input  logic                          upd_branch_i,
    input  logic                          upd_jal_i,
    input  logic                          upd_jalr_i,
    input  logic                          upd_inv_i,

    input  logic                          flush_all_req_i,
    output logic                          flush_all_done_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o,

    input  logic                          btb_init_i,
    output logic                          btb_upd_o,
    output logic [31:0]                   btb_pc_o,
    output logic [31:0]                   btb_target_o,
    output logic                          btb_branch_o,
    output logic                          btb_jal_o,
    output logic                          btb_jalr_o,
    output logic                          btb_flush_o
);

    localparam int IDX_W = $clog2(BTB_SIZE);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_INIT      = 2'd0,
        ST_RUN       = 2'd1,
        ST_FLUSH_ALL = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        branch;
        logic        jal;
        logic        jalr;
        logic        inv;
    } upd_entry_t;

    state_e             state_q;
    logic [PTR_W-1:0]   rptr_q;
    logic [PTR_W-1:0]   wptr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   idx_q;
    logic               done_q;
    logic               flush_pend_q;

    upd_entry_t         fifo_q [FIFO_DEPTH];
    upd_entry_t         push_entry;
    upd_entry_t         head_entry;

    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               walk_last;

    // -----------------------------------------------------------------------
    // Handshake and FIFO status: full/empty come from the occupancy counter,
    // so pointers can simply wrap.
    // -----------------------------------------------------------------------
    assign fifo_full   = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty  = (cnt_q == '0);
    assign upd_ready_o = (state_q == ST_RUN) && !fifo_full;
    assign push        = upd_valid_i && upd_ready_o;
    assign pop         = (state_q == ST_RUN) && !fifo_empty;
    assign walk_last   = (idx_q == IDX_W'(BTB_SIZE - 1));

    assign push_entry.pc     = upd_pc_i;
    assign push_entry.target = upd_target_i;
    assign push_entry.branch = upd_branch_i;
    assign push_entry.jal    = upd_jal_i;
    assign push_entry.jalr   = upd_jalr_i;
    assign push_entry.inv    = upd_inv_i;

    assign head_entry = fifo_q[rptr_q];

    // -----------------------------------------------------------------------
    // FIFO storage: payload only, no reset needed because every read is
    // qualified by the occupancy counter.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wptr_q] <= push_entry;
        end
    end

    // -----------------------------------------------------------------------
    // Control FSM, FIFO pointers, walk counter, done pulse.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q      <= ST_INIT;
            rptr_q       <= '0;
            wptr_q       <= '0;
            cnt_q        <= '0;
            idx_q        <= '0;
            done_q       <= 1'b0;
            flush_pend_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_INIT: begin
                    // The BTB init already clears every entry, so a flush
                    // request seen here only needs its done pulse.
                    if (btb_init_i) begin
                        if (flush_all_req_i) begin
                            flush_pend_q <= 1'b1;
                        end
                    end else begin
                        state_q      <= ST_RUN;
                        done_q       <= flush_pend_q || flush_all_req_i;
                        flush_pend_q <= 1'b0;
                    end
                end

                ST_RUN: begin
                    if (btb_init_i) begin
                        state_q <= ST_INIT;
                        rptr_q  <= '0;
                        wptr_q  <= '0;
                        cnt_q   <= '0;
                    end else if (flush_all_req_i) begin
                        // The request-cycle push and head drain still
                        // complete; everything left queued is dropped.
                        state_q <= ST_FLUSH_ALL;
                        rptr_q  <= '0;
                        wptr_q  <= '0;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                    end else begin
                        if (push) begin
                            wptr_q <= wptr_q + PTR_W'(1);
                        end
                        if (pop) begin
                            rptr_q <= rptr_q + PTR_W'(1);
                        end
                        if (push && !pop) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end else if (!push && pop) begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                end

                ST_FLUSH_ALL: begin
                    // Further flush requests are merged into this walk.
                    if (btb_init_i) begin
                        state_q <= ST_INIT;
                        idx_q   <= '0;
                    end else if (walk_last) begin
                        state_q <= ST_RUN;
                        idx_q   <= '0;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end

                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // BTB write port: decoded from registered state only.
    // -----------------------------------------------------------------------
    always_comb begin
        btb_upd_o    = 1'b0;
        btb_pc_o     = '0;
        btb_target_o = '0;
        btb_branch_o = 1'b0;
        btb_jal_o    = 1'b0;
        btb_jalr_o   = 1'b0;
        btb_flush_o  = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (!fifo_empty) begin
                    btb_upd_o    = 1'b1;
                    btb_pc_o     = head_entry.pc;
                    btb_target_o = head_entry.target;
                    btb_branch_o = head_entry.branch;
                    btb_jal_o    = head_entry.jal;
                    btb_jalr_o   = head_entry.jalr;
                    btb_flush_o  = head_entry.inv;
                end
            end
            ST_FLUSH_ALL: begin
                // Word-aligned PC selecting BTB index idx_q.
                btb_upd_o              = 1'b1;
                btb_flush_o            = 1'b1;
                btb_pc_o[IDX_W+1:2]    = idx_q;
            end
            default: begin
            end
        endcase
    end

    assign busy_o           = (state_q != ST_RUN);
    assign fifo_cnt_o       = cnt_q;
    assign flush_all_done_o = done_q;

endmodule
